stack_access_ctrl: RTL and testbench

- Sequences all traffic to the 16-stack pointer unit and the stack data RAM.
- Accepts push/pop requests from NREQ requesters (core, interrupt unit, …) and arbitrates them round-robin.
- Drives the pointer unit's strobe interface, performs the RAM write or read at the returned address, and retires pops with the read-done pulse.
- Returns data and an error flag; exactly one transaction is in flight at a time.

---
 rtl/stack_ctrl_pkg.sv | 24 ++
 rtl/stack_access_ctrl_if.sv | 31 +++
 rtl/stack_rr_arbiter.sv | 42 ++++
 rtl/stack_access_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_stack_access_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack access controller.
//   state_t    : controller FSM encoding (also exported on the debug port)
//   OP_PUSH/OP_POP : operation encoding carried on req_push
//   STK_IDX_W / STK_NUM_W / ADDR_W : pointer-unit index, stack number and RAM address widths
package stack_ctrl_pkg;

  localparam int STK_IDX_W = 9;
  localparam int STK_NUM_W = 4;
  localparam int ADDR_W    = 16;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    WAIT  = 3'd4,
    RET   = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/stack_access_ctrl_if.sv
// Requester-side bus of the stack access controller.
//   req_valid/req_push/req_id/req_wdata : one lane per requester
//   ack/rsp_data/rsp_err                : completion returned to the granted requester
// Handshake: a requester raises req_valid[i] with stable push/id/wdata and holds it
// until it sees ack[i]; ack[i] is a single-cycle pulse carrying rsp_data/rsp_err.
// Dropping req_valid before ack is not allowed; a request left high through the ack
// cycle is treated as a new request once the controller is idle again.
interface stack_access_ctrl_if
  import stack_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 16
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_push;
  logic [STK_NUM_W*NREQ-1:0] req_id;
  logic [DW*NREQ-1:0]        req_wdata;
  logic [NREQ-1:0]           ack;
  logic [DW-1:0]             rsp_data;
  logic                      rsp_err;

  modport master (
    output req_valid, req_push, req_id, req_wdata,
    input  ack, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_push, req_id, req_wdata,
    output ack, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_rr_arbiter.sv
// Round-robin arbiter for the stack access controller.
//   req    : pending requests
//   accept : grant is taken this cycle; pointer moves to grant+1
//   any    : at least one request pending
//   grant  : index of the first requester at or after the pointer
module stack_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int GW   = (NREQ > 2) ? 2 : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic            any,
  output logic [GW-1:0]   grant
);

  logic [GW-1:0] ptr;

  always_comb begin
    logic [GW-1:0] k;
    k     = '0;
    any   = 1'b0;
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = GW'((int'(ptr) + i) % NREQ);
      if (!any && req[k]) begin
        any   = 1'b1;
        grant = k;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: rtl/stack_access_ctrl.sv
// Stack access controller: arbitrates push/pop requests, drives the stack pointer
// unit strobes and performs the matching stack RAM access, one transaction at a time.
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : requester bus (req_*, ack, rsp_data, rsp_err)
//   stk_*             : pointer-unit strobe interface (stk_wsel/stk_addr/stk_ovf return)
//   mem_*             : stack data RAM port (mem_rvalid one or more cycles after mem_re)
//   dbg_state         : current FSM state
//   timeout_flag      : sticky RAM read timeout, only with STACK_CTRL_TIMEOUT_EN
// Optional feature macro: STACK_CTRL_TIMEOUT_EN bounds the RAM read wait to TIMEOUT cycles.
module stack_access_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  stack_access_ctrl_if.slave   bus,
  output logic                 stk_s,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [STK_NUM_W-1:0] stk_arg,
  output logic                 stk_readIt,
  input  logic                 stk_wsel,
  input  logic [ADDR_W-1:0]    stk_addr,
  input  logic                 stk_ovf,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_rvalid,
  output state_t               dbg_state
`ifdef STACK_CTRL_TIMEOUT_EN
  ,
  output logic                 timeout_flag
`endif
);

  localparam int GW = (NREQ > 2) ? 2 : 1;

  // Out-of-range parameters leave an empty marker block in the elaborated hierarchy.
  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_out_of_range
  end

  state_t                 state, state_d;
  logic                   any, accept;
  logic [GW-1:0]          grant, grant_q;
  logic                   op_q;
  logic [STK_NUM_W-1:0]   id_q;
  logic [DW-1:0]          wdata_q, data_q, data_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   err_q, err_d;
`ifdef STACK_CTRL_TIMEOUT_EN
  logic [7:0]             cnt;
  logic                   to_q, to_d;
`endif

  assign accept    = (state == IDLE) && any;
  assign dbg_state = state;

  stack_rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .accept (accept),
    .any    (any),
    .grant  (grant)
  );

  // Strobes decode the current state directly.
  assign stk_s      = (state == ISSUE);
  assign stk_push   = stk_s && (op_q == OP_PUSH);
  assign stk_pop    = stk_s && (op_q == OP_POP);
  assign stk_arg    = stk_s ? id_q : '0;
  assign stk_readIt = (state == RET);
  assign mem_we     = (state == WRITE);
  assign mem_re     = (state == READ);
  assign mem_addr   = (state == WRITE || state == READ || state == WAIT) ? addr_q : '0;
  assign mem_wdata  = mem_we ? wdata_q : '0;

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    err_d   = err_q;
    data_d  = data_q;
`ifdef STACK_CTRL_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state)
      IDLE:  if (any) state_d = ISSUE;
      ISSUE: begin
        addr_d = stk_addr;
        if (!stk_wsel) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (op_q == OP_PUSH) begin
          // A full stack reports overflow; the push is dropped without a RAM write.
          if (stk_ovf) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = READ;
        end
      end
      WRITE: state_d = DONE;
      READ:  state_d = WAIT;
      WAIT: begin
        if (mem_rvalid) begin
          data_d  = mem_rdata;
          state_d = RET;
        end
`ifdef STACK_CTRL_TIMEOUT_EN
        // Still retire the pop on timeout so the pointer unit stays consistent.
        else if (cnt == 8'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = RET;
        end
`endif
      end
      RET: begin
        // Underflow is only known when the pop retires.
        if (stk_ovf) begin
          err_d  = 1'b1;
          data_d = '0;
        end
`ifdef STACK_CTRL_TIMEOUT_EN
        if (to_q) begin
          err_d  = 1'b1;
          data_d = '0;
        end
`endif
        state_d = DONE;
      end
      DONE: begin
        err_d   = 1'b0;
        data_d  = '0;
`ifdef STACK_CTRL_TIMEOUT_EN
        to_d    = 1'b0;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant_q      <= '0;
      op_q         <= OP_POP;
      id_q         <= '0;
      wdata_q      <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      bus.ack      <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
    end else begin
      state  <= state_d;
      data_q <= data_d;
      err_q  <= err_d;
      addr_q <= addr_d;
      if (accept) begin
        grant_q <= grant;
        op_q    <= bus.req_push[grant];
        id_q    <= bus.req_id[grant*STK_NUM_W +: STK_NUM_W];
        wdata_q <= bus.req_wdata[grant*DW +: DW];
      end
      // Response registers are loaded on entry to DONE so they are valid during it.
      bus.ack      <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
      if (state_d == DONE) begin
        bus.ack[grant_q] <= 1'b1;
        bus.rsp_data     <= data_d;
        bus.rsp_err      <= err_d;
      end
    end
  end

`ifdef STACK_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      to_q         <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      cnt  <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
      to_q <= to_d;
      if (to_d) timeout_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Self-checking bench for stack_access_ctrl with a behavioural pointer unit and RAM.
module tb_stack_access_ctrl;
  import stack_ctrl_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 16;
  localparam int W    = NREQ + 1 + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stack_access_ctrl_if #(.NREQ(NREQ), .DW(DW)) bus ();

  logic            stk_s, stk_push, stk_pop, stk_readIt, stk_wsel, stk_ovf;
  logic [3:0]      stk_arg;
  logic [15:0]     stk_addr, mem_addr;
  logic            mem_we, mem_re, mem_rvalid;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  state_t          dbg_state;
`ifdef STACK_CTRL_TIMEOUT_EN
  logic            timeout_flag;
`endif

  stack_access_ctrl #(.NREQ(NREQ), .DW(DW), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stk_s(stk_s), .stk_push(stk_push), .stk_pop(stk_pop), .stk_arg(stk_arg),
    .stk_readIt(stk_readIt), .stk_wsel(stk_wsel), .stk_addr(stk_addr), .stk_ovf(stk_ovf),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .dbg_state(dbg_state)
`ifdef STACK_CTRL_TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- pointer unit model ----------------
  int         idx [16];
  logic [3:0] pend_id;
  bit         wsel_kill = 1'b0;

  function automatic logic [6:0] page(input logic [3:0] id);
    return {id, 3'b000} + 7'd8;
  endfunction

  always_comb begin
    stk_wsel = stk_s && !wsel_kill;
    stk_addr = '0;
    stk_ovf  = 1'b0;
    if (stk_s) begin
      if (stk_push) begin
        stk_addr = {page(stk_arg), 9'(idx[stk_arg] + 1)};
        stk_ovf  = (idx[stk_arg] == 511);
      end else begin
        stk_addr = {page(stk_arg), 9'(idx[stk_arg])};
        stk_ovf  = (idx[stk_arg] == 0);
      end
    end else if (stk_readIt) begin
      stk_ovf = (idx[pend_id] == 0);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) idx[i] <= 0;
      pend_id <= '0;
    end else begin
      if (stk_s && stk_push && stk_wsel && idx[stk_arg] != 511) idx[stk_arg] <= idx[stk_arg] + 1;
      if (stk_s && stk_pop) pend_id <= stk_arg;
      if (stk_readIt && idx[pend_id] != 0) idx[pend_id] <= idx[pend_id] - 1;
    end
  end

  // ---------------- RAM model ----------------
  logic [15:0] ram [0:65535];
  int          rd_delay = 1;
  bit          no_resp  = 1'b0;
  bit          rd_pend;
  int          rd_cnt;
  logic [15:0] rd_a;

  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_cnt  <= 0;
      rd_a    <= '0;
    end else if (mem_re) begin
      rd_pend <= 1'b1;
      rd_cnt  <= rd_delay;
      rd_a    <= mem_addr;
    end else if (rd_pend) begin
      if (rd_cnt <= 1) rd_pend <= 1'b0;
      else rd_cnt <= rd_cnt - 1;
    end
  end

  assign mem_rvalid = rd_pend && (rd_cnt == 1) && !no_resp;
  assign mem_rdata  = mem_rvalid ? ram[rd_a] : '0;

  // ---------------- scoreboard / monitor ----------------
  logic [W-1:0] exp_q[$];
  logic [3:0]   last_arg;
  logic [15:0]  last_we_addr, last_we_data, last_re_addr;
  int           we_cnt = 0;
  int           readit_cnt = 0;
  int           ack_cnt = 0;
  bit           prev_ack = 1'b0;

  function automatic logic [NREQ-1:0] oh(input int r);
    logic [NREQ-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      if (stk_s) last_arg <= stk_arg;
      if (mem_we) begin
        we_cnt       <= we_cnt + 1;
        last_we_addr <= mem_addr;
        last_we_data <= mem_wdata;
      end
      if (mem_re) last_re_addr <= mem_addr;
      if (stk_readIt) readit_cnt <= readit_cnt + 1;
      if (|bus.ack) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check("ack_rsp", 32'({bus.ack, bus.rsp_err, bus.rsp_data}), 32'(e));
        check("ack_width", 32'(prev_ack), 32'(0));
        ack_cnt <= ack_cnt + 1;
      end
    end
    prev_ack <= |bus.ack;
  end

  // ---------------- driver ----------------
  task automatic do_txn(input int r, input bit push, input logic [3:0] id, input logic [15:0] wd,
                        input bit eerr, input logic [15:0] edata, input int elat);
    int n;
    bit got;
    @(negedge clk);
    exp_q.push_back({oh(r), eerr, edata});
    bus.req_push[r]         = push;
    bus.req_id[r*4 +: 4]    = id;
    bus.req_wdata[r*16 +: 16] = wd;
    bus.req_valid[r]        = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.ack[r]) got = 1'b1;
    end
    bus.req_valid[r] = 1'b0;
    check("ack_seen", 32'(got), 32'(1));
    if (elat > 0) check("latency", 32'(n), 32'(elat));
  endtask

  initial begin
    int rb, wb, k;
    for (int i = 0; i < 65536; i++) ram[i] = '0;
    bus.req_valid = '0;
    bus.req_push  = '0;
    bus.req_id    = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    check("rst_strobes", 32'({stk_s, stk_push, stk_pop, stk_readIt, stk_arg}), 0);
    check("rst_mem", 32'({mem_we, mem_re, mem_addr, mem_wdata}), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;

    // single push
    do_txn(0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 16'h0000, 3);
    check("push_arg", 32'(last_arg), 32'd3);
    check("push_we_addr", 32'(last_we_addr), 32'({7'h20, 9'd1}));
    check("push_we_data", 32'(last_we_data), 32'hBEEF);

    // pop it back with a 1-cycle RAM
    rb = readit_cnt;
    do_txn(0, 1'b0, 4'd3, 16'h0, 1'b0, 16'hBEEF, 5);
    check("pop_re_addr", 32'(last_re_addr), 32'({7'h20, 9'd1}));
    check("pop_readit", 32'(readit_cnt - rb), 32'd1);

    // pop of an empty stack
    rb = readit_cnt;
    do_txn(1, 1'b0, 4'd7, 16'h0, 1'b1, 16'h0000, 5);
    check("empty_readit", 32'(readit_cnt - rb), 32'd1);

    // slower RAM
    do_txn(1, 1'b1, 4'd2, 16'h1234, 1'b0, 16'h0000, 3);
    rd_delay = 3;
    do_txn(1, 1'b0, 4'd2, 16'h0, 1'b0, 16'h1234, 7);
    rd_delay = 1;

    // pointer unit without address-valid
    wb = we_cnt;
    wsel_kill = 1'b1;
    do_txn(0, 1'b1, 4'd9, 16'h5555, 1'b1, 16'h0000, 2);
    wsel_kill = 1'b0;
    check("nowsel_no_write", 32'(we_cnt - wb), 0);

    // fill stack 0, then overflow
    for (int i = 0; i < 511; i++)
      do_txn(0, 1'b1, 4'd0, 16'(i + 1), 1'b0, 16'h0000, (i == 0) ? 3 : 0);
    check("fill_writes", 32'(we_cnt - wb), 32'd511);
    wb = we_cnt;
    do_txn(0, 1'b1, 4'd0, 16'hDEAD, 1'b1, 16'h0000, 2);
    check("ovf_no_write", 32'(we_cnt - wb), 0);
    do_txn(0, 1'b0, 4'd0, 16'h0, 1'b0, 16'd511, 5);

`ifdef STACK_CTRL_TIMEOUT_EN
    do_txn(0, 1'b1, 4'd11, 16'h7777, 1'b0, 16'h0000, 3);
    no_resp = 1'b1;
    rb = readit_cnt;
    do_txn(0, 1'b0, 4'd11, 16'h0, 1'b1, 16'h0000, 259);
    check("timeout_readit", 32'(readit_cnt - rb), 32'd1);
    check("timeout_flag", 32'(timeout_flag), 32'd1);
    no_resp = 1'b0;
`endif

    // reset while waiting for RAM data
    do_txn(1, 1'b1, 4'd3, 16'hCAFE, 1'b0, 16'h0000, 3);
    no_resp = 1'b1;
    @(negedge clk);
    bus.req_push[0]     = 1'b0;
    bus.req_id[3:0]     = 4'd3;
    bus.req_valid[0]    = 1'b1;
    repeat (4) @(negedge clk);
    check("wait_state", 32'(dbg_state), 32'(WAIT));
    check("wait_addr", 32'(mem_addr), 32'({7'h20, 9'd1}));
    rst = 1'b1;
    #1;
    bus.req_valid[0] = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_outputs", 32'({bus.ack, bus.rsp_err, mem_re, mem_we, stk_s, stk_readIt}), 0);
    check("abort_mem_addr", 32'(mem_addr), 0);
`ifdef STACK_CTRL_TIMEOUT_EN
    check("abort_timeout_flag", 32'(timeout_flag), 0);
`endif
    k = ack_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    no_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_no_ack", 32'(ack_cnt - k), 0);
    do_txn(1, 1'b1, 4'd4, 16'hA5A5, 1'b0, 16'h0000, 3);
    do_txn(1, 1'b0, 4'd4, 16'h0, 1'b0, 16'hA5A5, 5);

    // contention: both requesters hold valid across four transactions
    @(negedge clk);
    exp_q.push_back({oh(0), 1'b0, 16'h0000});
    exp_q.push_back({oh(1), 1'b0, 16'h0000});
    exp_q.push_back({oh(0), 1'b0, 16'h0000});
    exp_q.push_back({oh(1), 1'b0, 16'h0000});
    bus.req_push  = 2'b11;
    bus.req_id    = {4'd6, 4'd5};
    bus.req_wdata = {16'h6666, 16'h5555};
    k = ack_cnt;
    bus.req_valid = 2'b11;
    for (int n = 0; n < 200 && (ack_cnt - k) < 4; n++) @(negedge clk);
    bus.req_valid = 2'b00;
    check("contention_acks", 32'(ack_cnt - k), 32'd4);
    do_txn(1, 1'b0, 4'd6, 16'h0, 1'b0, 16'h6666, 5);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
